// File: rtl/simplez_mem_arbiter.sv
// simplez_mem_arbiter: round-robin two-port arbiter (CPU / loader) for the Simplez main memory
module simplez_mem_arbiter #(
    parameter int DATAW = 12,
    parameter int ADDRW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [ADDRW-1:0] c_addr,
    input  logic [DATAW-1:0] c_wdata,
    output logic [DATAW-1:0] c_rdata,
    output logic             c_ack,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [ADDRW-1:0] l_addr,
    input  logic [DATAW-1:0] l_wdata,
    output logic [DATAW-1:0] l_rdata,
    output logic             l_ack,
    input  logic             l_lock,
    output logic [ADDRW-1:0] m_addr,
    output logic             m_wr,
    output logic [DATAW-1:0] m_wdata,
    input  logic [DATAW-1:0] m_rdata,
    output logic             owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t state;
    logic   prio;
    logic   we_q;
    logic   c_el;
    logic   l_el;
    logic   win;
    // eligibility and round-robin winner (1 = loader)
    always_comb begin
        c_el = c_req & ~l_lock;
        l_el = l_req;
        win  = (c_el & l_el) ? prio : l_el;
    end
    // transaction sequencer; everything moves on the falling edge with the CPU and memory
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            we_q    <= 1'b0;
            owner   <= 1'b0;
            m_addr  <= '0;
            m_wr    <= 1'b0;
            m_wdata <= '0;
            c_rdata <= '0;
            l_rdata <= '0;
            c_ack   <= 1'b0;
            l_ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (c_el | l_el) begin
                    m_addr  <= win ? l_addr : c_addr;
                    m_wr    <= win ? l_we : c_we;
                    we_q    <= win ? l_we : c_we;
                    m_wdata <= win ? l_wdata : c_wdata;
                    owner   <= win;
                    prio    <= ~win;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    m_wr  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!we_q && owner) l_rdata <= m_rdata;
                    if (!we_q && !owner) c_rdata <= m_rdata;
                    l_ack <= owner;
                    c_ack <= ~owner;
                    state <= RESP;
                end
                default: begin
                    c_ack <= 1'b0;
                    l_ack <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// tb_simplez_mem_arbiter: directed table and sequence checks for the memory arbiter
module tb_simplez_mem_arbiter;
    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        init = 1'b1;
    logic        c_req = 0, c_we = 0, l_req = 0, l_we = 0, l_lock = 0;
    logic [8:0]  c_addr = 0, l_addr = 0;
    logic [11:0] c_wdata = 0, l_wdata = 0;
    logic [11:0] c_rdata, l_rdata, m_wdata, m_rdata;
    logic        c_ack, l_ack, m_wr, owner;
    logic [8:0]  m_addr;
    logic [11:0] mem [512];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [8:0]  addr;
        logic [11:0] wd;
        logic [11:0] exp_rd;
    } vec_t;

    simplez_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_ack(l_ack), .l_lock(l_lock),
        .m_addr(m_addr), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // synchronous-read memory on the falling edge
    always @(negedge clk) begin
        if (init) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
            mem[9'o100] <= 12'o7123;
        end else begin
            if (m_wr) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o, expected %0o", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_c_ack"}, c_ack, 0);
        chk({nm, "_l_ack"}, l_ack, 0);
        chk({nm, "_m_wr"}, m_wr, 0);
        chk({nm, "_c_rdata"}, c_rdata, 0);
        chk({nm, "_l_rdata"}, l_rdata, 0);
        chk({nm, "_m_addr"}, m_addr, 0);
        chk({nm, "_m_wdata"}, m_wdata, 0);
        chk({nm, "_owner"}, owner, 0);
    endtask

    task automatic txn(input vec_t v);
        int  wr_cnt = 0;
        bit  done = 0;
        logic a, xa;
        @(posedge clk);
        if (v.port) begin
            l_we = v.we; l_addr = v.addr; l_wdata = v.wd; l_req = 1;
        end else begin
            c_we = v.we; c_addr = v.addr; c_wdata = v.wd; c_req = 1;
        end
        for (int k = 1; k <= 10 && !done; k++) begin
            @(posedge clk);
            a  = v.port ? l_ack : c_ack;
            xa = v.port ? c_ack : l_ack;
            if (m_wr) wr_cnt++;
            chk("txn_other_ack", xa, 0);
            if (k == 1) begin
                chk("txn_m_addr", m_addr, v.addr);
                chk("txn_owner", owner, v.port);
                if (v.we) chk("txn_m_wdata", m_wdata, v.wd);
            end
            if (a) begin
                done = 1;
                chk("txn_latency", k, 3);
                chk("txn_rdata", v.port ? l_rdata : c_rdata, v.exp_rd);
                if (v.port) l_req = 0; else c_req = 0;
            end
        end
        chk("txn_ack_seen", done, 1);
        chk("txn_m_wr_cycles", wr_cnt, v.we);
    endtask

    task automatic pair();
        bit cd = 0, ld = 0;
        @(posedge clk);
        c_we = 0; c_addr = 9'o100; c_req = 1;
        l_we = 0; l_addr = 9'o005; l_req = 1;
        for (int k = 1; k <= 20 && !(cd && ld); k++) begin
            @(posedge clk);
            chk("pair_ack_overlap", c_ack & l_ack, 0);
            if (k == 1) chk("pair_owner_first", owner, 0);
            if (k == 5) chk("pair_owner_second", owner, 1);
            if (c_ack && !cd) begin
                cd = 1; c_req = 0;
                chk("pair_c_latency", k, 3);
                chk("pair_c_rdata", c_rdata, 12'o7123);
            end
            if (l_ack && !ld) begin
                ld = 1; l_req = 0;
                chk("pair_l_latency", k, 7);
                chk("pair_l_rdata", l_rdata, 12'o4321);
            end
        end
        chk("pair_both_done", cd & ld, 1);
    endtask

    initial begin
        vec_t tbl [7];
        int cnt, la, last, lastc;
        tbl[0] = '{1'b0, 1'b0, 9'o100, 12'o0000, 12'o7123};
        tbl[1] = '{1'b1, 1'b1, 9'o005, 12'o4321, 12'o0000};
        tbl[2] = '{1'b0, 1'b0, 9'o005, 12'o0000, 12'o4321};
        tbl[3] = '{1'b1, 1'b0, 9'o100, 12'o0000, 12'o7123};
        tbl[4] = '{1'b0, 1'b1, 9'o777, 12'o1234, 12'o4321};
        tbl[5] = '{1'b1, 1'b0, 9'o777, 12'o0000, 12'o1234};
        tbl[6] = '{1'b0, 1'b0, 9'o000, 12'o0000, 12'o0000};

        repeat (2) @(posedge clk);
        init = 0;
        chk_zero_outputs("reset");
        rst = 0;

        for (int i = 0; i < 7; i++) txn(tbl[i]);

        rst = 1;
        @(posedge clk);
        rst = 0;
        pair();
        pair();

        @(posedge clk);
        l_lock = 1; c_we = 0; c_addr = 9'o100; c_req = 1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            cnt += int'(c_ack);
        end
        chk("lock_no_c_ack", cnt, 0);
        chk("lock_m_wr_low", m_wr, 0);
        l_lock = 0;
        cnt = 0;
        for (int k = 1; k <= 10 && cnt == 0; k++) begin
            @(posedge clk);
            if (c_ack) begin
                cnt = k;
                c_req = 0;
            end
        end
        chk("unlock_c_latency", cnt, 3);

        @(posedge clk);
        l_lock = 1;
        l_we = 0; l_addr = 9'o100; l_req = 1;
        c_we = 0; c_addr = 9'o005; c_req = 1;
        la = 0; last = 0; lastc = 0;
        for (int k = 1; k <= 60 && la < 5; k++) begin
            @(posedge clk);
            chk("starve_ack_overlap", c_ack & l_ack, 0);
            if (l_ack) begin
                la++;
                if (la == 1) chk("starve_l_first", k, 3);
                else if (la <= 4) chk("starve_l_period", k - last, 4);
                else begin
                    chk("starve_l_after_c", k - lastc, 4);
                    l_req = 0;
                end
                last = k;
                if (la == 4) l_lock = 0;
            end
            if (c_ack) begin
                chk("starve_c_after_unlock", k - last, 4);
                chk("starve_l_count_before_c", la, 4);
                chk("starve_c_rdata", c_rdata, 12'o4321);
                lastc = k;
                c_req = 0;
            end
        end
        chk("starve_l_total", la, 5);
        chk("starve_c_served", lastc != 0, 1);

        txn('{1'b0, 1'b0, 9'o100, 12'o0000, 12'o7123});
        @(posedge clk);
        l_we = 1; l_addr = 9'o010; l_wdata = 12'o5555; l_req = 1;
        @(posedge clk);
        chk("rst_mid_m_wr_before", m_wr, 1);
        #2 rst = 1;
        #1 chk_zero_outputs("rst_mid");
        l_req = 0; l_we = 0;
        #1 rst = 0;
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            cnt += int'(c_ack) + int'(l_ack);
        end
        chk("rst_mid_no_ack", cnt, 0);
        pair();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
